// File: rtl/controller_tc1_reader.sv
// controller_tc1_reader: free-running SPI master for thermocouple channel 1.
// Every SAMPLE_PERIOD clocks it reads one 32-bit MAX31855-format frame and
// publishes a packed 25-bit status word with a 7-bit sequence number.
// Optional feature macro: CONTROLLER_TC1_FAULT_HOLD_EN. When it is defined,
// a faulted frame (F[16]=1) keeps the previous temperature field.
module controller_tc1_reader #(
    parameter int CLK_DIV       = 25,
    parameter int SAMPLE_PERIOD = 5000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        spi_miso,
    output logic        spi_sck,
    output logic        spi_cs_n,
    output logic [24:0] status_out,
    output logic        sample_strobe
);

    localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PER_LAST = PW'(SAMPLE_PERIOD - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_SHIFT  = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_UPDATE = 3'd4;

    logic          miso_meta;
    logic          miso_sync;
    logic [PW-1:0] period_cnt;
    logic          start;
    logic [2:0]    state;
    logic [DW-1:0] div_cnt;
    logic          div_done;
    logic [4:0]    bit_cnt;
    logic [31:0]   shift_reg;
    logic [24:0]   next_status;

    // Two-flop synchronizer for the converter's asynchronous data line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            miso_meta <= 1'b0;
            miso_sync <= 1'b0;
        end else begin
            miso_meta <= spi_miso;
            miso_sync <= miso_meta;
        end
    end

    // Free-running sample period counter; the start pulse is its last count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            period_cnt <= '0;
        else if (period_cnt == PER_LAST)
            period_cnt <= '0;
        else
            period_cnt <= period_cnt + PW'(1);
    end

    assign start    = (period_cnt == PER_LAST);
    assign div_done = (div_cnt == DIV_LAST);

    // Status word built from the completed frame in shift_reg.
    always_comb begin
        next_status         = status_out;
        next_status[24:18]  = status_out[24:18] + 7'd1;
        next_status[17]     = shift_reg[2];
        next_status[16]     = shift_reg[1];
        next_status[15]     = shift_reg[0];
        next_status[14]     = shift_reg[16];
`ifdef CONTROLLER_TC1_FAULT_HOLD_EN
        if (!shift_reg[16])
            next_status[13:0] = shift_reg[31:18];
`else
        next_status[13:0]   = shift_reg[31:18];
`endif
    end

    // Frame sequencer; spi_sck doubles as the low/high phase flag in SHIFT.
    // Start pulses arriving outside IDLE are simply ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            div_cnt       <= '0;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            spi_sck       <= 1'b0;
            spi_cs_n      <= 1'b1;
            status_out    <= '0;
            sample_strobe <= 1'b0;
        end else begin
            sample_strobe <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_SETUP;
                        spi_cs_n <= 1'b0;
                        div_cnt  <= '0;
                    end
                end
                S_SETUP: begin
                    if (div_done) begin
                        state   <= S_SHIFT;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                S_SHIFT: begin
                    if (div_done) begin
                        div_cnt <= '0;
                        if (!spi_sck) begin
                            spi_sck <= 1'b1;
                        end else begin
                            // End of high phase: capture this bit.
                            spi_sck   <= 1'b0;
                            shift_reg <= {shift_reg[30:0], miso_sync};
                            bit_cnt   <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd31)
                                state <= S_HOLD;
                        end
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                S_HOLD: begin
                    if (div_done) begin
                        // CS rise, status write and strobe share this edge.
                        state         <= S_UPDATE;
                        div_cnt       <= '0;
                        spi_cs_n      <= 1'b1;
                        status_out    <= next_status;
                        sample_strobe <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                S_UPDATE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
